mem_arbiter: RTL
================

# mem_arbiter

Byte-serial memory bus arbiter sitting between the CPU core and the 8-bit external RAM/IO bus. It shares the single bus between the instruction-fetch port (32-bit word reads) and the load/store port (1/2/4-byte reads and writes). It sequences each multi-byte access over consecutive cycles, honours the 1-cycle RAM read latency, `rdy_in` pauses and UART back-pressure, and returns assembled little-endian words to the requester.

## Interface
- `IO_SEL`, default 2'b11: value of `addr[17:16]` that marks the IO region.
- `clk_in`  in  1  system clock; all logic is rising-edge.
- `rst_n_in`  in  1  reset, asynchronous and active-low.
- `rdy_in`  in  1  high = run; low = pause, with all state frozen.
- `if_req_i`  in  1  fetch request; held until `if_done_o`.
- `if_addr_i`  in  32  fetch byte address.
- `if_flush_i`  in  1  abort any fetch in progress (jump taken).
- `if_done_o`  out  1  one-cycle pulse: `if_data_o` is valid.
- `if_data_o`  out  32  fetched word.
- `ls_req_i`  in  1  load/store request; held until `ls_done_o`.
- `ls_wr_i`  in  1  1 = store, 0 = load.
- `ls_size_i`  in  2  byte count minus 1; legal values are 0, 1 and 3.
- `ls_addr_i`  in  32  byte address.
- `ls_wdata_i`  in  32  store data; byte 0 is bits 7:0.
- `ls_done_o`  out  1  one-cycle completion pulse.
- `ls_rdata_o`  out  32  load data, zero-extended; the core sign-extends.
- `mem_din`  in  8  RAM/IO read byte; it belongs to the address driven in the previous cycle.
- `mem_dout`  out  8  write byte.
- `mem_a`  out  32  bus address.
- `mem_wr`  out  1  1 = write.
- `io_buffer_full`  in  1  UART transmit buffer full.

## Operation
- **States:** IDLE, IF_RD, LS_RD, LS_WR, DONE.
- **IDLE, arbitration:**
  - `ls_req_i` has priority over `if_req_i`.
  - The granted address and size are latched.
  - Fetch size is fixed at 4 bytes.
- **No preemption:** a granted transfer runs to completion. The only exception is a fetch aborted by `if_flush_i`.
- **Counters:** `issue_cnt` and `recv_cnt`, 3 bits each.
  - Byte *k* uses address `base + k` with 32-bit wrap-around.
  - Read byte *k* is stored into result bits `[8k+7:8k]`.
- **IF_RD and LS_RD:**
  - Drive `mem_a = base + issue_cnt` and increment `issue_cnt` while `issue_cnt` ≤ size.
  - Each cycle after an issue, capture `mem_din` and increment `recv_cnt`.
  - When the last byte is received, go to DONE.
- **LS_WR:**
  - Drive `mem_wr = 1`, `mem_a = base + issue_cnt` and `mem_dout` = the matching byte, then increment.
  - After the last byte, go to DONE.
- **IO write stall:** if `mem_a[17:16] == IO_SEL` and `io_buffer_full` = 1, force `mem_wr` to 0 and hold the byte. It is retried every cycle until the buffer is no longer full.
- **DONE:**
  - Pulse the owner's `*_done_o` with its data.
  - Return to IDLE; the requester drops `req` in this same cycle.
- **Flush:**
  - `if_flush_i` in IF_RD sends the block to IDLE on the next edge, with no done pulse.
  - During DONE, when the owner is the fetch port, `if_done_o` is gated low combinationally.
  - `if_flush_i` has no effect on load/store transfers.
- **`rdy_in` low:**
  - All registers hold and `mem_wr` is forced to 0.
  - The in-flight read byte is discarded: `issue_cnt` is reset to `recv_cnt`, so that byte is re-issued after resume.
- **Idle outputs:** `mem_a` = 0, `mem_wr` = 0, `mem_dout` = 0.

## Timing
- **Reset values:**
  - State is IDLE and both counters are 0.
  - All outputs are 0: both done signals, both data outputs, `mem_a`, `mem_dout` and `mem_wr`.
- **Read of N bytes, grant in cycle 0:**
  - Addresses are driven in cycles 1..N.
  - Bytes are captured at the end of cycles 2..N+1.
  - Done is high in cycle N+2.
- **Write of N bytes, no IO stall:** bytes are written in cycles 1..N and done is high in cycle N+1.
- **Back-to-back:** there is one IDLE cycle after DONE, so the minimum fetch-to-fetch spacing is 7 cycles.
- **Simultaneous `if_req_i` and `ls_req_i` in IDLE:** load/store is granted; the fetch waits.
- **Simultaneous flush and new fetch request:** the flush wins. The new `if_req_i` is arbitrated in the following IDLE cycle.
- **`rst_n_in` low mid-transfer:** the block goes to IDLE immediately and `mem_wr` drops asynchronously.

## Structure
- **Package `mem_arb_pkg`:**
  - state enum
  - `IO_SEL` constant
  - size encodings `SZ_B` = 0, `SZ_H` = 1, `SZ_W` = 3
  - owner encoding `OWN_IF`/`OWN_LS`
- **Sub-module `mem_byte_seq`:**
  - contains the issue/receive counters, address increment, byte-lane assembly and write-lane select
  - instantiated once
- **`mem_arbiter`:** holds arbitration, the state machine and the stall/flush logic.

## Test plan
- **Fetch:** `if_req_i` @0x100, RAM holds 13 05 00 00 → `mem_a` = 0x100..0x103 in cycles 1–4; `if_done_o` in cycle 6 with `if_data_o` = 0x00000513.
- **Contention:** `if_req_i` and `ls_req_i` (load word @0x200) in the same cycle → the load completes first; the fetch begins in the cycle after the load's DONE+IDLE.
- **IO store with back-pressure:** store byte 0x41 @0x30000 with `io_buffer_full` = 1 for 3 cycles → `mem_wr` stays 0 for those 3 cycles, then 1 for one cycle with `mem_dout` = 0x41; `ls_done_o` follows on the next cycle.
- **Flush:** `if_flush_i` asserted in cycle 3 of a fetch → no `if_done_o`; IDLE in cycle 4; no further fetch addresses driven.
- **Pause:** `rdy_in` low for 2 cycles after byte 1 is issued in a halfword load @0x10 → byte 1 is re-issued after resume and `ls_rdata_o` is correct.
- **Async reset:** `rst_n_in` asserted mid-store → `mem_wr` is 0 immediately; all outputs are 0; state is IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-serial memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_RD,
    ST_LS_RD,
    ST_LS_WR,
    ST_DONE
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

  // addr[17:16] value that selects the IO region
  localparam logic [1:0] IO_SEL = 2'b11;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd3;

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: latches a granted transfer, steps issue/receive counters,
// produces bus addresses and write lanes, and assembles little-endian read words.
module mem_byte_seq
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        start_i,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic        stall_i,
  input  logic [31:0] base_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  din_i,
  output logic        issue_ok_o,
  output logic        last_o,
  output logic [31:0] addr_o,
  output logic [7:0]  wr_byte_o,
  output logic [31:0] result_d_o
);

  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  size_q, size_d;
  logic [2:0]  issue_q, issue_d;
  logic [2:0]  recv_q, recv_d;
  logic [2:0]  size_ext;
  logic        capture;
  logic        wr_fire;

  always_comb begin
    size_ext   = {1'b0, size_q};
    issue_ok_o = (issue_q <= size_ext);
    capture    = rd_en_i && (issue_q > recv_q);
    wr_fire    = wr_en_i && issue_ok_o && !stall_i;
    addr_o     = base_q + {29'd0, issue_q};
    wr_byte_o  = wdata_q[{issue_q[1:0], 3'b000} +: 8];
    result_d_o = result_q;
    if (capture) begin
      result_d_o[{recv_q[1:0], 3'b000} +: 8] = din_i;
    end
    last_o = rd_en_i ? (capture && (recv_q == size_ext))
                     : (wr_fire && (issue_q == size_ext));
  end

  // A pause rewinds issue_cnt to recv_cnt so the in-flight read byte is re-issued
  always_comb begin
    base_d   = base_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    issue_d  = issue_q;
    recv_d   = recv_q;
    if (start_i) begin
      base_d   = base_i;
      size_d   = size_i;
      wdata_d  = wdata_i;
      result_d = 32'd0;
      issue_d  = 3'd0;
      recv_d   = 3'd0;
    end else if (!rdy) begin
      issue_d = recv_q;
    end else if (rd_en_i) begin
      if (issue_ok_o) issue_d = issue_q + 3'd1;
      if (capture)    recv_d  = recv_q + 3'd1;
      result_d = result_d_o;
    end else if (wr_fire) begin
      issue_d = issue_q + 3'd1;
      recv_d  = recv_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= 32'd0;
      size_q   <= 2'd0;
      wdata_q  <= 32'd0;
      result_q <= 32'd0;
      issue_q  <= 3'd0;
      recv_q   <= 3'd0;
    end else begin
      base_q   <= base_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      issue_q  <= issue_d;
      recv_q   <= recv_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the 8-bit RAM/IO bus between instruction fetch and load/store,
// handling arbitration, flush, rdy pauses and UART write back-pressure.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_done_o,
  output logic [31:0] if_data_o,
  input  logic        ls_req_i,
  input  logic        ls_wr_i,
  input  logic [1:0]  ls_size_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_done_o,
  output logic [31:0] ls_rdata_o,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic        start;
  logic        rd_en;
  logic        wr_en;
  logic        stall;
  logic        issue_ok;
  logic        seq_last;
  logic [31:0] seq_addr;
  logic [7:0]  seq_wr_byte;
  logic [31:0] seq_result_d;
  logic [31:0] grant_addr;
  logic [1:0]  grant_size;

  mem_byte_seq u_seq (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .rdy        (rdy_in),
    .start_i    (start),
    .rd_en_i    (rd_en),
    .wr_en_i    (wr_en),
    .stall_i    (stall),
    .base_i     (grant_addr),
    .size_i     (grant_size),
    .wdata_i    (ls_wdata_i),
    .din_i      (mem_din),
    .issue_ok_o (issue_ok),
    .last_o     (seq_last),
    .addr_o     (seq_addr),
    .wr_byte_o  (seq_wr_byte),
    .result_d_o (seq_result_d)
  );

  // Bus outputs are idle-zero; a full UART buffer holds the IO write byte in place
  always_comb begin
    rd_en      = (state_q == ST_IF_RD) || (state_q == ST_LS_RD);
    wr_en      = (state_q == ST_LS_WR);
    stall      = (seq_addr[17:16] == IO_SEL) && io_buffer_full;
    grant_addr = ls_req_i ? ls_addr_i : if_addr_i;
    grant_size = ls_req_i ? ls_size_i : SZ_W;
    mem_a      = ((rd_en || wr_en) && issue_ok) ? seq_addr : 32'd0;
    mem_dout   = (wr_en && issue_ok) ? seq_wr_byte : 8'd0;
    mem_wr     = wr_en && issue_ok && rdy_in && !stall;
    if_done_o  = (state_q == ST_DONE) && (owner_q == OWN_IF) && rdy_in && !if_flush_i;
    ls_done_o  = (state_q == ST_DONE) && (owner_q == OWN_LS) && rdy_in;
    if_data_o  = if_data_q;
    ls_rdata_o = ls_rdata_q;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    start      = 1'b0;
    if (rdy_in) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ls_req_i) begin
            start   = 1'b1;
            owner_d = OWN_LS;
            state_d = ls_wr_i ? ST_LS_WR : ST_LS_RD;
          end else if (if_req_i && !if_flush_i) begin
            start   = 1'b1;
            owner_d = OWN_IF;
            state_d = ST_IF_RD;
          end
        end
        ST_IF_RD: begin
          if (if_flush_i) begin
            state_d = ST_IDLE;
          end else if (seq_last) begin
            if_data_d = seq_result_d;
            state_d   = ST_DONE;
          end
        end
        ST_LS_RD: begin
          if (seq_last) begin
            ls_rdata_d = seq_result_d;
            state_d    = ST_DONE;
          end
        end
        ST_LS_WR: begin
          if (seq_last) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

endmodule
